// File: rtl/cordic_sched.sv
// Round-robin scheduler sharing one pipelined CORDIC core among NREQ requesters.
// Results return LAT+1 cycles after accept; requests stall (req_ready low) only while draining for a mode change.
module cordic_sched #(
    parameter int M    = 32,
    parameter int NREQ = 4,
    parameter int LAT  = 6,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_mode,
    input  logic [M*NREQ-1:0]   req_x,
    output logic [1:0]          cor_mode,
    output logic [M-1:0]        cor_x,
    input  logic [M-1:0]        cor_x_n,
    input  logic [M-1:0]        cor_y_n,
    input  logic [M-1:0]        cor_z_n,
    output logic [NREQ-1:0]     res_valid,
    output logic [M-1:0]        res_x,
    output logic [M-1:0]        res_y,
    output logic [M-1:0]        res_z,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    state_t           state;
    logic [1:0]       cur_mode;
    logic [1:0]       pend_mode;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   pend_id;
    logic             pend_first;
    tag_t [LAT:0]     tags;

    logic [IDW-1:0]   rr_hi;
    logic [IDW-1:0]   rr_lo;
    logic             found_hi;
    logic             found_lo;
    logic [IDW-1:0]   g;
    logic [1:0]       g_mode;
    logic [M-1:0]     g_x;
    logic             pend_vld;
    logic             any_valid;
    logic             mode_ok;
    logic             hs;
    logic             tags_any;
    logic [IDW-1:0]   ptr_nxt;

    // Round-robin search split into two passes: requesters at or above ptr first, then wrap to the bottom.
    always_comb begin
        rr_hi    = '0;
        rr_lo    = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        pend_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[IDW'(i)] && (IDW'(i) >= ptr) && !found_hi) begin
                rr_hi    = IDW'(i);
                found_hi = 1'b1;
            end
            if (req_valid[IDW'(i)] && !found_lo) begin
                rr_lo    = IDW'(i);
                found_lo = 1'b1;
            end
            if (req_valid[IDW'(i)] && (pend_id == IDW'(i))) begin
                pend_vld = 1'b1;
            end
        end
    end

    // The requester that forced a drain keeps its claim through the drain and the first check after it.
    always_comb begin
        g = found_hi ? rr_hi : rr_lo;
        if ((state == DRAIN) || (pend_first && pend_vld)) begin
            g = pend_id;
        end
        g_mode = '0;
        g_x    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g == IDW'(i)) begin
                g_mode = req_mode[2*i +: 2];
                g_x    = req_x[M*i +: M];
            end
        end
    end

    always_comb begin
        any_valid = |req_valid;
        mode_ok   = (g_mode == cur_mode);
        req_ready = '0;
        if ((state != DRAIN) && any_valid && mode_ok) begin
            for (int i = 0; i < NREQ; i++) begin
                if (g == IDW'(i)) begin
                    req_ready[IDW'(i)] = 1'b1;
                end
            end
        end
        hs      = |(req_valid & req_ready);
        ptr_nxt = (g == IDW'(NREQ-1)) ? '0 : g + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cur_mode   <= 2'b00;
            pend_mode  <= 2'b00;
            pend_id    <= '0;
            pend_first <= 1'b0;
            ptr        <= '0;
            cor_x      <= '0;
        end else begin
            case (state)
                IDLE, ISSUE: begin
                    pend_first <= 1'b0;
                    if (!any_valid) begin
                        state <= IDLE;
                    end else if (mode_ok) begin
                        state <= ISSUE;
                    end else begin
                        pend_id   <= g;
                        pend_mode <= g_mode;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!tags_any) begin
                        cur_mode   <= pend_mode;
                        pend_first <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (hs) begin
                cor_x <= g_x;
                ptr   <= ptr_nxt;
            end
        end
    end

    // Tag pipe mirrors the core pipeline so each result can be steered back to its owner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tags <= '0;
        end else begin
            tags <= {tags[LAT-1:0], (hs ? tag_t'({1'b1, g}) : tag_t'('0))};
        end
    end

    always_comb begin
        tags_any  = 1'b0;
        res_valid = '0;
        for (int s = 0; s <= LAT; s++) begin
            tags_any = tags_any | tags[s].vld;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (tags[LAT].vld && (tags[LAT].id == IDW'(i))) begin
                res_valid[IDW'(i)] = 1'b1;
            end
        end
    end

    assign cor_mode = cur_mode;
    assign res_x    = cor_x_n;
    assign res_y    = cor_y_n;
    assign res_z    = cor_z_n;
    assign busy     = (state != IDLE) || tags_any;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_cordic_sched;

    localparam int M    = 32;
    localparam int NREQ = 4;
    localparam int LAT  = 6;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [2*NREQ-1:0]   req_mode;
    logic [M*NREQ-1:0]   req_x;
    logic [1:0]          cor_mode;
    logic [M-1:0]        cor_x;
    logic [M-1:0]        cor_x_n;
    logic [M-1:0]        cor_y_n;
    logic [M-1:0]        cor_z_n;
    logic [NREQ-1:0]     res_valid;
    logic [M-1:0]        res_x;
    logic [M-1:0]        res_y;
    logic [M-1:0]        res_z;
    logic                busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    cordic_sched #(.M(M), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_x(req_x),
        .cor_mode(cor_mode), .cor_x(cor_x),
        .cor_x_n(cor_x_n), .cor_y_n(cor_y_n), .cor_z_n(cor_z_n),
        .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_z(res_z),
        .busy(busy)
    );

    // Stand-in core: mode-dependent functions so a result computed under the wrong mode is visible.
    function automatic logic [31:0] fx(input logic [1:0] m, input logic [31:0] x);
        return x ^ ({30'd0, m} * 32'h9e3779b9);
    endfunction
    function automatic logic [31:0] fy(input logic [1:0] m, input logic [31:0] x);
        return x + {30'd0, m} + 32'h0000_1000;
    endfunction
    function automatic logic [31:0] fz(input logic [1:0] m, input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ {m, 30'd0};
    endfunction

    logic [33:0] cpipe [LAT];
    initial for (int i = 0; i < LAT; i++) cpipe[i] = '0;
    always @(posedge clk) begin
        cpipe[0] <= {cor_mode, cor_x};
        for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
    assign cor_x_n = fx(cpipe[LAT-1][33:32], cpipe[LAT-1][31:0]);
    assign cor_y_n = fy(cpipe[LAT-1][33:32], cpipe[LAT-1][31:0]);
    assign cor_z_n = fz(cpipe[LAT-1][33:32], cpipe[LAT-1][31:0]);

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: grant rules, drain rule (pipe empty once LAT+1 cycles have passed since the last accept),
    // and a queue of results owed at accept cycle + LAT + 1.
    typedef struct {
        int         due;
        int         id;
        logic [1:0] mode;
        logic [31:0] x;
    } exp_t;

    exp_t       owed [$];
    int         m_ptr, m_last, m_pid, g;
    logic [1:0] m_mode, m_pmode;
    bit         m_drain, m_idle, m_first;

    always @(negedge clk) begin : monitor
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] erv;
        logic            ebusy;
        bit              found;
        bit              have;
        exp_t            e;
        if (rst !== 1'b1) begin
            m_ptr = 0; m_last = -100; m_pid = 0; m_mode = 2'b00; m_pmode = 2'b00;
            m_drain = 0; m_idle = 1; m_first = 0;
            owed.delete();
        end else begin
            er    = '0;
            g     = 0;
            ebusy = !m_idle || ((cyc - m_last) <= LAT + 1);
            checks++;
            if (busy !== ebusy) $display("FAIL mon_busy cyc=%0d: got %b expected %b", cyc, busy, ebusy);
            if (busy !== ebusy) errors++;
            checks++;
            if (cor_mode !== m_mode) begin
                errors++;
                $display("FAIL mon_cor_mode cyc=%0d: got %b expected %b", cyc, cor_mode, m_mode);
            end
            if (m_drain) begin
                if ((cyc - m_last) > LAT + 1) begin
                    m_mode = m_pmode; m_drain = 0; m_first = 1;
                end
            end else begin
                if (req_valid != '0) begin
                    if (m_first && req_valid[IDW'(m_pid)]) begin
                        g = m_pid;
                    end else begin
                        found = 0;
                        for (int k = 0; k < NREQ; k++) begin
                            if (!found && req_valid[IDW'((m_ptr + k) % NREQ)]) begin
                                g = (m_ptr + k) % NREQ;
                                found = 1;
                            end
                        end
                    end
                    if (req_mode[2*g +: 2] == m_mode) er[IDW'(g)] = 1'b1;
                    else begin
                        m_drain = 1; m_pid = g; m_pmode = req_mode[2*g +: 2];
                    end
                    m_idle = 0;
                end else begin
                    m_idle = 1;
                end
                m_first = 0;
            end
            checks++;
            if (req_ready !== er) begin
                errors++;
                $display("FAIL mon_ready cyc=%0d: got %b expected %b", cyc, req_ready, er);
            end
            if (er != '0) begin
                m_ptr  = (g + 1) % NREQ;
                m_last = cyc;
                owed.push_back('{cyc + LAT + 1, g, req_mode[2*g +: 2], req_x[M*g +: M]});
            end
            erv  = '0;
            have = 0;
            if (owed.size() > 0 && owed[0].due == cyc) begin
                e = owed.pop_front();
                erv[IDW'(e.id)] = 1'b1;
                have = 1;
            end
            checks++;
            if (res_valid !== erv) begin
                errors++;
                $display("FAIL mon_res_valid cyc=%0d: got %b expected %b", cyc, res_valid, erv);
            end
            if (have) begin
                checks++;
                if (res_x !== fx(e.mode, e.x) || res_y !== fy(e.mode, e.x) || res_z !== fz(e.mode, e.x)) begin
                    errors++;
                    $display("FAIL mon_res_data cyc=%0d: got %h/%h/%h expected %h/%h/%h", cyc, res_x, res_y, res_z,
                             fx(e.mode, e.x), fy(e.mode, e.x), fz(e.mode, e.x));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic [1:0] m, input logic [31:0] x);
        req_valid[IDW'(i)] = v;
        req_mode[2*i +: 2] = m;
        req_x[M*i +: M]    = x;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        req_valid = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (res_valid !== '0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cor_x !== '0) begin errors++; $display("FAIL reset_cor_x: got %h expected 0", cor_x); end
        checks++; if (cor_mode !== 2'b00) begin errors++; $display("FAIL reset_cor_mode: got %b expected 00", cor_mode); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [31:0] x;
        x = 32'h1921fb54;
        do_reset();
        set_req(0, 1'b1, 2'b00, x);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'b00, 32'd0);
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (cor_x !== x) begin errors++; $display("FAIL single_cor_x: got %h expected %h", cor_x, x); end
            end
            checks++;
            if (c == LAT + 1) begin
                if (res_valid !== 4'b0001) begin errors++; $display("FAIL single_res_valid c=%0d: got %b expected 0001", c, res_valid); end
                checks++;
                if (res_x !== x || res_y !== fy(2'b00, x) || res_z !== fz(2'b00, x)) begin
                    errors++; $display("FAIL single_res_data: got %h/%h/%h expected %h/%h/%h", res_x, res_y, res_z, x, fy(2'b00, x), fz(2'b00, x));
                end
            end else if (res_valid !== '0) begin
                errors++; $display("FAIL single_early_res c=%0d: got %b expected 0000", c, res_valid);
            end
            @(posedge clk); #1;
        end
        idle_cycles(2);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b00, 32'ha000_0000 | i);
        for (int c = 0; c <= LAT + 4; c++) begin
            @(negedge clk);
            exp = 4'b0001 << (c % NREQ);
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_ready c=%0d: got %b expected %b", c, req_ready, exp); end
            if (c >= LAT + 1) begin
                exp = 4'b0001 << ((c - LAT - 1) % NREQ);
                checks++;
                if (res_valid !== exp || res_x !== (32'ha000_0000 | ((c - LAT - 1) % NREQ))) begin
                    errors++; $display("FAIL rr_result c=%0d: got %b/%h expected %b/%h", c, res_valid, res_x, exp, 32'ha000_0000 | ((c - LAT - 1) % NREQ));
                end
            end
            @(posedge clk); #1;
        end
        idle_cycles(LAT + 3);
    endtask

    task automatic test_mode_switch();
        logic [31:0] x1;
        x1 = 32'h56b851ec;
        do_reset();
        for (int c = 0; c <= 2 * LAT + 4; c++) begin
            set_req(0, 1'b1, 2'b00, 32'h1111_0000);
            set_req(1, (c <= LAT + 3), 2'b11, x1);
            @(negedge clk);
            if (c == 0) begin
                checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ms_first c=%0d: got %b expected 0001", c, req_ready); end
            end else if (c <= LAT + 2) begin
                checks++;
                if (req_ready !== 4'b0000 || busy !== 1'b1 || cor_mode !== 2'b00) begin
                    errors++; $display("FAIL ms_drain c=%0d: got rdy=%b busy=%b mode=%b expected 0000/1/00", c, req_ready, busy, cor_mode);
                end
            end else if (c == LAT + 3) begin
                checks++;
                if (req_ready !== 4'b0010 || cor_mode !== 2'b11) begin
                    errors++; $display("FAIL ms_switch c=%0d: got rdy=%b mode=%b expected 0010/11", c, req_ready, cor_mode);
                end
            end else if (c == 2 * LAT + 4) begin
                checks++;
                if (res_valid !== 4'b0010 || res_x !== fx(2'b11, x1)) begin
                    errors++; $display("FAIL ms_result: got %b/%h expected 0010/%h", res_valid, res_x, fx(2'b11, x1));
                end
            end
            @(posedge clk); #1;
        end
        idle_cycles(LAT + 4);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_req(2, 1'b1, 2'b00, $urandom);
            @(negedge clk);
            checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_mf_issue c=%0d: got %b expected 0100", c, req_ready); end
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < LAT + 4; c++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== '0 || busy !== 1'b0 || cor_x !== '0 || cor_mode !== 2'b00) begin
                errors++; $display("FAIL rst_mf_quiet c=%0d: got rv=%b busy=%b x=%h mode=%b expected 0/0/0/00", c, res_valid, busy, cor_x, cor_mode);
            end
            @(posedge clk); #1;
        end
        set_req(1, 1'b1, 2'b00, 32'h0000_0111);
        set_req(3, 1'b1, 2'b00, 32'h0000_0333);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_mf_ptr: got %b expected 0010", req_ready); end
        @(posedge clk); #1;
        idle_cycles(LAT + 3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs [$];
        do_reset();
        for (int c = 0; c < 2 * LAT; c++) begin
            xs.push_back($urandom);
            set_req(2, 1'b1, 2'b00, xs[c]);
            @(negedge clk);
            checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_ready c=%0d: got %b expected 0100", c, req_ready); end
            if (c >= 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy c=%0d: got %b expected 1", c, busy); end
            end
            if (c >= LAT + 1) begin
                checks++;
                if (res_valid !== 4'b0100 || res_x !== xs[c - LAT - 1]) begin
                    errors++; $display("FAIL b2b_result c=%0d: got %b/%h expected 0100/%h", c, res_valid, res_x, xs[c - LAT - 1]);
                end
            end
            @(posedge clk); #1;
        end
        idle_cycles(LAT + 3);
    endtask

    task automatic test_drain_abandon();
        logic [31:0] xb;
        xb = 32'h2468_ace0;
        do_reset();
        for (int c = 0; c <= 2 * LAT + 4; c++) begin
            set_req(0, (c == 0) || (c >= 2 && c <= LAT + 3), (c == 0) ? 2'b00 : 2'b01, (c == 0) ? 32'h0 : xb);
            set_req(3, (c == 1) || (c == 2), 2'b01, 32'h7777_7777);
            @(negedge clk);
            if (c == 0) begin
                checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL da_first: got %b expected 0001", req_ready); end
            end else if (c <= LAT + 2) begin
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL da_drain c=%0d: got %b expected 0000", c, req_ready); end
            end else if (c == LAT + 3) begin
                checks++;
                if (req_ready !== 4'b0001 || cor_mode !== 2'b01) begin
                    errors++; $display("FAIL da_grant: got rdy=%b mode=%b expected 0001/01", req_ready, cor_mode);
                end
            end else if (c == 2 * LAT + 4) begin
                checks++;
                if (res_valid !== 4'b0001 || res_x !== fx(2'b01, xb)) begin
                    errors++; $display("FAIL da_result: got %b/%h expected 0001/%h", res_valid, res_x, fx(2'b01, xb));
                end
            end
            @(posedge clk); #1;
        end
        idle_cycles(LAT + 4);
    endtask

    task automatic test_random(input int n);
        logic [NREQ-1:0] hs;
        do_reset();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            checks++;
            if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0)) begin
                errors++; $display("FAIL rand_ready_shape c=%0d: got rdy=%b with valid=%b", c, req_ready, req_valid);
            end
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[IDW'(i)] && !hs[IDW'(i)]) begin
                    if ($urandom_range(0, 99) < 4) req_valid[IDW'(i)] = 1'b0;
                end else begin
                    set_req(i, ($urandom_range(0, 99) < 55),
                            ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00, $urandom);
                end
            end
        end
        idle_cycles(LAT + 4);
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_mode  = '0;
        req_x     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_mode_switch();
        test_reset_midflight();
        test_back_to_back();
        test_drain_abandon();
        test_random(600);
        checks++;
        if (owed.size() != 0) begin
            errors++; $display("FAIL results_outstanding: got %0d pending expected 0", owed.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Shares one pipelined CORDIC core among NREQ requesters.
- Each cycle, picks one request round-robin, drives the core's mode and x inputs, and tags the operation with the requester ID.
- Routes each core result back to its owner exactly LAT+1 cycles after the request handshake.
- The core's mode input applies to the whole pipeline, so the scheduler drains in-flight work before changing mode.

Parameters:
M, 32, operand/result width (signed fixed point, Q3.29 as used by the core).
NREQ, 4, number of requesters.
LAT, 6, core latency: cycles from cor_x/cor_mode sampled to matching x_n/y_n/z_n valid.
IDW, 2, requester ID width, equal to clog2(NREQ).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-low reset; sampled on clk rising edge; 0 = reset.
req_valid  in  NREQ  per-requester request valid.
req_ready  out  NREQ  per-requester accept; at most one bit high; combinational from state.
req_mode  in  2*NREQ  packed per-requester CORDIC mode; requester i uses bits [2i+1:2i].
req_x  in  M*NREQ  packed per-requester operand; requester i uses bits [M*i+M-1:M*i].
cor_mode  out  2  mode to core; registered.
cor_x  out  M  operand to core; registered.
cor_x_n  in  M  core x output.
cor_y_n  in  M  core y output.
cor_z_n  in  M  core z output.
res_valid  out  NREQ  one-hot result strobe, single cycle.
res_x  out  M  result x; equals cor_x_n in the strobe cycle.
res_y  out  M  result y; equals cor_y_n in the strobe cycle.
res_z  out  M  result z; equals cor_z_n in the strobe cycle.
busy  out  1  1 when state is not IDLE or any tag is in flight.

Behaviour:
- Reset (rst=0 at an edge) clears:
  - state <= IDLE, cur_mode <= 2'b00, ptr <= 0, cor_x <= 0, cor_mode <= 0;
  - every tag valid bit.
- From the cycle after reset: res_valid=0, req_ready=0, busy=0. In-flight results are discarded.
- Grant: g = first i with req_valid[i]=1, searching from ptr upward mod NREQ. In DRAIN, g is locked to pend_id.
- Handshake occurs in a cycle with req_valid[g]=1 and req_ready[g]=1. On that edge:
  - cor_x <= req_x[g];
  - tag pipe stage 0 <= {1, g};
  - ptr <= (g+1) mod NREQ.
- With no handshake, tag stage 0 <= {0, x} and cor_x holds its value.
- Tag pipe is LAT+1 stages and shifts every cycle. At the last stage, if the valid bit is 1: res_valid[id]=1 and res_x/y/z pass through from the core.
- Result timing: a handshake in cycle k produces a res_valid pulse in cycle k+LAT+1.
- Requesters have no result backpressure; results are never dropped or reordered.
- FSM:
  - IDLE / ISSUE, with any req_valid:
    - if req_mode[g]==cur_mode: req_ready[g]=1 and state -> ISSUE;
    - else: no ready, pend_id <= g, pend_mode <= req_mode[g], state -> DRAIN.
  - IDLE / ISSUE, with no req_valid: state -> IDLE.
  - DRAIN:
    - req_ready=0;
    - when all tag valids are 0: cur_mode <= pend_mode, cor_mode <= pend_mode, state -> ISSUE.
    - pend_id gets the first grant check after the switch. If pend_id has dropped valid by then, normal arbitration resumes.
- cor_mode always equals cur_mode. It never changes while any tag is valid.
- Minimum mode-switch penalty is 1 DRAIN cycle with an empty pipe. Worst case is LAT+2 cycles.
- req_x and req_mode must stay stable while req_valid is high and not yet accepted. The scheduler never accepts without both valid and ready.
- Ptr wraps from NREQ-1 to 0.
- Same-mode streams issue one operation per cycle with no bubbles.
- Simultaneous events:
  - a result retire and a new issue in the same cycle are independent;
  - a requester may be both issuing and receiving a result in the same cycle.

Test Plan:
1. Single request: requester 0 sends mode 2'b00, x=32'h1921fb54 at cycle 3 -> req_ready[0]=1 at cycle 3; cor_x=32'h1921fb54 at cycle 4; res_valid=4'b0001 only at cycle 3+LAT+1=10; res_* equal core outputs at that cycle.
2. Round-robin: all 4 requesters valid, mode 00, held continuously -> grants 0,1,2,3,0,... in consecutive cycles; res_valid sequence 0001,0010,0100,1000 starting LAT+1 cycles after the first grant; no gaps.
3. Mode switch:
   - requester 0 streams mode 00; requester 1 requests mode 2'b11, x=32'h56b851ec;
   - when g=1, expect DRAIN with req_ready=0 until the tag pipe empties, then cor_mode=11;
   - requester 1 is accepted first after the switch; no result ever returns while cor_mode differs from its issue mode.
4. Reset mid-flight: issue 3 operations, then assert rst=0 for 1 cycle two cycles later -> res_valid stays 0 for all subsequent cycles; busy=0; cor_x=0; ptr=0; cur_mode=00.
5. Back-to-back retire and issue: requester 2 issues every cycle for 2*LAT cycles -> from cycle LAT+1 onward res_valid[2]=1 every cycle while req_ready[2]=1 every cycle; busy=1 throughout.
6. Drain abandon: requester 3 triggers DRAIN, then drops req_valid before the drain completes; requester 0 stays valid with the new mode -> mode switches to pend_mode and requester 0 is granted; no stall beyond drain completion.
